// File: rtl/sram_buf_pkg.sv
// Shared types for the SRAM load buffer: region select, load FSM states, default lane count.
package sram_buf_pkg;

  typedef enum logic {
    REG_IMG = 1'b0,
    REG_WT  = 1'b1
  } region_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } ld_state_e;

  localparam int WORD_W_DEF = 32;
  localparam int ELEM_W_DEF = 16;
  // Elements per SRAM word for the default widths.
  localparam int EPW = WORD_W_DEF / ELEM_W_DEF;

endpackage

// File: rtl/sram_elem_mem.sv
// Element array with one multi-lane write port (per-lane enables, consecutive
// addresses from a base) and one registered read port. Reads return old data
// on a same-address write; out-of-range read addresses return zero.
module sram_elem_mem #(
  parameter  int DEPTH  = 64,
  parameter  int ELEM_W = 16,
  parameter  int EPW    = 2,
  parameter  int PTR_W  = 11,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [EPW-1:0]        wr_en,
  input  logic [PTR_W-1:0]      wr_base,
  input  logic [EPW*ELEM_W-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [ELEM_W-1:0]     rd_data
);

  logic [ELEM_W-1:0] mem [DEPTH];
  logic [ELEM_W-1:0] rd_data_d;
  logic [ELEM_W-1:0] rd_data_q;

  // Lane i of the incoming word lands at wr_base + i.
  always_ff @(posedge clk) begin
    for (int i = 0; i < EPW; i++) begin
      if (wr_en[i]) begin
        mem[AW'(wr_base + PTR_W'(i))] <= wr_data[i*ELEM_W +: ELEM_W];
      end
    end
  end

  // Read mux, masking addresses beyond the array for non-power-of-2 depths.
  always_comb begin
    rd_data_d = '0;
    if ({1'b0, rd_addr} < (AW+1)'(DEPTH)) begin
      rd_data_d = mem[rd_addr];
    end
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sram_load_buffer.sv
// Loads packed SRAM words into an image or weight element region and serves
// one registered read per region per cycle to the MAC datapath.
module sram_load_buffer
  import sram_buf_pkg::*;
#(
  parameter  int WORD_W    = 32,
  parameter  int ELEM_W    = 16,
  parameter  int IMG_DEPTH = 64,
  parameter  int WT_DEPTH  = 1024,
  localparam int LEN_W     = $clog2(WT_DEPTH + 1),
  localparam int IMG_AW    = $clog2(IMG_DEPTH),
  localparam int WT_AW     = $clog2(WT_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_sel,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              sram_valid,
  input  logic [WORD_W-1:0] sram_data,
  output logic              sram_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic              img_valid,
  output logic              wt_valid,
  input  logic [IMG_AW-1:0] img_rd_addr,
  output logic [ELEM_W-1:0] img_rd_data,
  input  logic [WT_AW-1:0]  wt_rd_addr,
  output logic [ELEM_W-1:0] wt_rd_data
);

  // Elements per word for this instance's widths.
  localparam int LANES = WORD_W / ELEM_W;

  ld_state_e        state_q, state_d;
  region_e          sel_q, sel_d;
  logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             img_valid_q, img_valid_d;
  logic             wt_valid_q, wt_valid_d;
  logic             err_q, err_d;
  logic [LANES-1:0] lane_en;
  logic [LEN_W-1:0] sel_depth;

  assign sel_depth = load_sel ? LEN_W'(WT_DEPTH) : LEN_W'(IMG_DEPTH);

  // Next-state, counters, lane enables and valid-flag updates.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    wr_ptr_d    = wr_ptr_q;
    rem_d       = rem_q;
    img_valid_d = img_valid_q;
    wt_valid_d  = wt_valid_q;
    err_d       = 1'b0;
    lane_en     = '0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          if (load_len > sel_depth) begin
            err_d = 1'b1;
          end else if (load_len == '0) begin
            state_d = FIN;
            sel_d   = region_e'(load_sel);
            if (load_sel) wt_valid_d  = 1'b1;
            else          img_valid_d = 1'b1;
          end else begin
            state_d  = LOAD;
            sel_d    = region_e'(load_sel);
            wr_ptr_d = '0;
            rem_d    = load_len;
            if (load_sel) wt_valid_d  = 1'b0;
            else          img_valid_d = 1'b0;
          end
        end
      end
      LOAD: begin
        if (sram_valid) begin
          // Only lanes still inside the requested length are written.
          for (int i = 0; i < LANES; i++) begin
            lane_en[i] = (LEN_W'(i) < rem_q);
          end
          wr_ptr_d = wr_ptr_q + LEN_W'(LANES);
          if (rem_q <= LEN_W'(LANES)) begin
            rem_d   = '0;
            state_d = FIN;
            if (sel_q == REG_WT) wt_valid_d  = 1'b1;
            else                 img_valid_d = 1'b1;
          end else begin
            rem_d = rem_q - LEN_W'(LANES);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset aborts any load and invalidates both regions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= REG_IMG;
      wr_ptr_q    <= '0;
      rem_q       <= '0;
      img_valid_q <= 1'b0;
      wt_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      wr_ptr_q    <= wr_ptr_d;
      rem_q       <= rem_d;
      img_valid_q <= img_valid_d;
      wt_valid_q  <= wt_valid_d;
      err_q       <= err_d;
    end
  end

  assign sram_ready = (state_q == LOAD);
  assign load_busy  = (state_q != IDLE);
  assign load_done  = (state_q == FIN);
  assign load_err   = err_q;
  assign img_valid  = img_valid_q;
  assign wt_valid   = wt_valid_q;

  sram_elem_mem #(
    .DEPTH (IMG_DEPTH),
    .ELEM_W(ELEM_W),
    .EPW   (LANES),
    .PTR_W (LEN_W)
  ) u_img_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  ((sel_q == REG_IMG) ? lane_en : '0),
    .wr_base(wr_ptr_q),
    .wr_data(sram_data),
    .rd_addr(img_rd_addr),
    .rd_data(img_rd_data)
  );

  sram_elem_mem #(
    .DEPTH (WT_DEPTH),
    .ELEM_W(ELEM_W),
    .EPW   (LANES),
    .PTR_W (LEN_W)
  ) u_wt_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  ((sel_q == REG_WT) ? lane_en : '0),
    .wr_base(wr_ptr_q),
    .wr_data(sram_data),
    .rd_addr(wt_rd_addr),
    .rd_data(wt_rd_data)
  );

endmodule

// File: tb/tb_sram_load_buffer.sv
// Randomized bench for sram_load_buffer with an array-based reference model.
module tb_sram_load_buffer;

  localparam int IMG_DEPTH = 64;
  localparam int WT_DEPTH  = 1024;
  localparam int EPW       = 2;
  localparam int LEN_W     = 11;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic        load_sel;
  logic [10:0] load_len;
  logic        sram_valid;
  logic [31:0] sram_data;
  logic        sram_ready;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic        img_valid;
  logic        wt_valid;
  logic [5:0]  img_rd_addr;
  logic [15:0] img_rd_data;
  logic [9:0]  wt_rd_addr;
  logic [15:0] wt_rd_data;

  sram_load_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_sel   (load_sel),
    .load_len   (load_len),
    .sram_valid (sram_valid),
    .sram_data  (sram_data),
    .sram_ready (sram_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .img_valid  (img_valid),
    .wt_valid   (wt_valid),
    .img_rd_addr(img_rd_addr),
    .img_rd_data(img_rd_data),
    .wt_rd_addr (wt_rd_addr),
    .wt_rd_data (wt_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: region contents, which entries have been written, valid flags.
  logic [15:0] img_m [IMG_DEPTH];
  logic [15:0] wt_m  [WT_DEPTH];
  bit          img_k [IMG_DEPTH];
  bit          wt_k  [WT_DEPTH];
  bit          img_v;
  bit          wt_v;

  int n_tests;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_img_valid"}, 32'(img_valid), 32'(img_v));
    chk({tag, "_wt_valid"}, 32'(wt_valid), 32'(wt_v));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one load request and drive words until it finishes; abort_words > 0
  // pulses rst after that many accepted words.
  task automatic do_load(input bit sel, input int len, input bit pattern, input bit gaps,
                         input int abort_words);
    logic [31:0] data;
    logic [15:0] exp_i, exp_w;
    bit ki, kw, v;
    int rem, ptr, acc, cyc, depth, n;
    depth = sel ? WT_DEPTH : IMG_DEPTH;
    load_start = 1'b1;
    load_sel   = sel;
    load_len   = 11'(len);
    sram_valid = 1'b0;
    tick();
    load_start = 1'b0;
    if (len > depth) begin
      chk("err_pulse", 32'(load_err), 1);
      chk("err_busy", 32'(load_busy), 0);
      chk_flags("err");
      tick();
      chk("err_clear", 32'(load_err), 0);
      chk("err_idle", 32'(load_busy), 0);
      return;
    end
    if (len == 0) begin
      if (sel) wt_v = 1'b1; else img_v = 1'b1;
      chk("zero_done", 32'(load_done), 1);
      chk("zero_busy", 32'(load_busy), 1);
      chk_flags("zero");
      tick();
      chk("zero_done_end", 32'(load_done), 0);
      chk("zero_idle", 32'(load_busy), 0);
      return;
    end
    if (sel) wt_v = 1'b0; else img_v = 1'b0;
    chk_flags("start");
    rem = len; ptr = 0; acc = 0; cyc = 0;
    while (rem > 0) begin
      if (cyc >= 4000) begin
        chk("load_timeout", 0, 1);
        sram_valid = 1'b0;
        return;
      end
      chk("ready", 32'(sram_ready), 1);
      chk("busy", 32'(load_busy), 1);
      chk("no_done", 32'(load_done), 0);
      v    = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      data = pattern ? {16'(ptr + 2), 16'(ptr + 1)} : $urandom;
      load_start = ($urandom_range(0, 3) == 0);
      load_sel   = 1'($urandom_range(0, 1));
      load_len   = 11'($urandom_range(0, 1100));
      if (!sel) begin
        img_rd_addr = 6'(ptr);
        wt_rd_addr  = 10'($urandom_range(0, WT_DEPTH - 1));
      end else begin
        wt_rd_addr  = 10'(ptr);
        img_rd_addr = 6'd63;
      end
      exp_i = img_m[img_rd_addr]; ki = img_k[img_rd_addr];
      exp_w = wt_m[wt_rd_addr];   kw = wt_k[wt_rd_addr];
      if (v) begin
        n = (rem < EPW) ? rem : EPW;
        for (int i = 0; i < n; i++) begin
          if (sel) begin wt_m[ptr + i] = data[16*i +: 16]; wt_k[ptr + i] = 1'b1; end
          else     begin img_m[ptr + i] = data[16*i +: 16]; img_k[ptr + i] = 1'b1; end
        end
        ptr += EPW; rem -= n; acc++;
        if (rem == 0) begin
          if (sel) wt_v = 1'b1; else img_v = 1'b1;
        end
      end
      sram_valid = v;
      sram_data  = data;
      tick();
      cyc++;
      if (ki) chk("img_rd", 32'(img_rd_data), 32'(exp_i));
      if (kw) chk("wt_rd", 32'(wt_rd_data), 32'(exp_w));
      chk("no_err", 32'(load_err), 0);
      chk_flags("load");
      if (abort_words > 0 && acc == abort_words && rem > 0) begin
        sram_valid = 1'b0;
        load_start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        img_v = 1'b0; wt_v = 1'b0;
        chk("abort_ready", 32'(sram_ready), 0);
        chk("abort_busy", 32'(load_busy), 0);
        chk("abort_done", 32'(load_done), 0);
        chk("abort_img_rd", 32'(img_rd_data), 0);
        chk("abort_wt_rd", 32'(wt_rd_data), 0);
        chk_flags("abort");
        return;
      end
    end
    sram_valid = 1'b0;
    load_start = 1'b0;
    chk("words", acc, (len + EPW - 1) / EPW);
    chk("done", 32'(load_done), 1);
    chk("fin_ready", 32'(sram_ready), 0);
    chk("fin_busy", 32'(load_busy), 1);
    tick();
    chk("done_once", 32'(load_done), 0);
    chk("end_busy", 32'(load_busy), 0);
    chk("end_ready", 32'(sram_ready), 0);
    chk_flags("end");
  endtask

  task automatic rd_img(input int addr, input int exp);
    img_rd_addr = 6'(addr);
    tick();
    chk("img_rd_dir", 32'(img_rd_data), 32'(exp));
  endtask

  // Random reads of both regions against the model.
  task automatic rd_rand(input int n);
    logic [15:0] ei, ew;
    bit ki, kw;
    for (int k = 0; k < n; k++) begin
      img_rd_addr = 6'($urandom_range(0, IMG_DEPTH - 1));
      wt_rd_addr  = 10'($urandom_range(0, WT_DEPTH - 1));
      ei = img_m[img_rd_addr]; ki = img_k[img_rd_addr];
      ew = wt_m[wt_rd_addr];   kw = wt_k[wt_rd_addr];
      tick();
      if (ki) chk("img_rd_rand", 32'(img_rd_data), 32'(ei));
      if (kw) chk("wt_rd_rand", 32'(wt_rd_data), 32'(ew));
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, len;
    n_tests = 0; n_fail = 0;
    img_v = 1'b0; wt_v = 1'b0;
    for (int i = 0; i < IMG_DEPTH; i++) begin img_m[i] = '0; img_k[i] = 1'b0; end
    for (int i = 0; i < WT_DEPTH; i++)  begin wt_m[i] = '0;  wt_k[i] = 1'b0;  end
    rst = 1'b1; load_start = 1'b0; load_sel = 1'b0; load_len = '0;
    sram_valid = 1'b0; sram_data = '0; img_rd_addr = '0; wt_rd_addr = '0;
    tick(); tick();
    chk("rst_ready", 32'(sram_ready), 0);
    chk("rst_busy", 32'(load_busy), 0);
    chk("rst_done", 32'(load_done), 0);
    chk("rst_err", 32'(load_err), 0);
    chk("rst_img_rd", 32'(img_rd_data), 0);
    chk("rst_wt_rd", 32'(wt_rd_data), 0);
    chk_flags("rst");
    rst = 1'b0;
    tick();

    // Full image load with a counting pattern, then directed reads.
    do_load(1'b0, 64, 1'b1, 1'b0, 0);
    for (int a = 0; a < 4; a++) rd_img(a, a + 1);
    chk("img_valid_t1", 32'(img_valid), 1);

    // Fill the weight region, then a short gapped weight load.
    do_load(1'b1, 1024, 1'b0, 1'b1, 0);
    do_load(1'b1, 5, 1'b0, 1'b1, 0);
    wt_rd_addr = 10'd5;
    tick();
    chk("wt_addr5_kept", 32'(wt_rd_data), 32'(wt_m[5]));
    chk("wt_valid_t2", 32'(wt_valid), 1);

    // Rejected and zero-length requests.
    do_load(1'b0, 65, 1'b0, 1'b0, 0);
    do_load(1'b1, 1025, 1'b0, 1'b0, 0);
    do_load(1'b0, 0, 1'b0, 1'b0, 0);

    // Reset mid weight load, then a fresh load.
    do_load(1'b1, 1024, 1'b0, 1'b0, 10);
    do_load(1'b1, 40, 1'b0, 1'b1, 0);

    // Back-to-back image then weight load, image addr 63 read during the latter.
    do_load(1'b0, 64, 1'b0, 1'b1, 0);
    do_load(1'b1, 200, 1'b0, 1'b1, 0);

    // Random loads and reads.
    for (int k = 0; k < 6; k++) begin
      sel = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, sel ? 300 : IMG_DEPTH));
      do_load(sel[0], len, 1'b0, 1'b1, 0);
      rd_rand(20);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
